// File: rtl/axi_clint_xbar_if.sv
// axi_clint_xbar_if: single-ID AXI4 bundle shared by the core side and the SoC side of the CLINT router.
interface axi_clint_xbar_if;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast, rid
    );
    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/axi_clint_xbar.sv
// axi_clint_xbar: one-outstanding AXI4 router; CLINT window served from a local mtime, everything else forwarded.
module axi_clint_xbar #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
    parameter int unsigned MTIME_DIV  = 1
) (
    input  logic              clock,
    input  logic              reset,
    axi_clint_xbar_if.slave   s,
    axi_clint_xbar_if.master  m,
    output logic [63:0]       mtime
);
    typedef enum logic [3:0] {IDLE, AR_EXT, R_EXT, R_CLINT, AW_EXT, W_EXT, B_EXT, W_CLINT, B_CLINT} state_t;
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, shadow_q, shadow_d, off, clint_rdata;
    logic [3:0]  id_q, id_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic        idle, ar_hs, aw_hs, ar_hit, aw_hit, off_lo, off_hi, tick;

    assign idle   = state_q == IDLE;
    assign ar_hs  = idle && s.arvalid;
    assign aw_hs  = idle && s.awvalid && !s.arvalid;
    assign ar_hit = (s.araddr & CLINT_MASK) == CLINT_BASE;
    assign aw_hit = (s.awaddr & CLINT_MASK) == CLINT_BASE;
    assign off    = addr_q & ~CLINT_MASK;
    assign off_lo = off == 32'h0000_BFF8;
    assign off_hi = off == 32'h0000_BFFC;
    assign tick   = presc_q == 16'(MTIME_DIV - 1);
    assign mtime  = mtime_q;
    assign clint_rdata = off_lo ? mtime_q[31:0] : off_hi ? shadow_q : 32'd0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        case (state_q)
            IDLE:
                if (ar_hs) begin
                    state_d = ar_hit ? R_CLINT : AR_EXT;
                    {addr_d, id_d, len_d, size_d, burst_d} = {s.araddr, s.arid, s.arlen, s.arsize, s.arburst};
                end else if (aw_hs) begin
                    state_d = aw_hit ? W_CLINT : AW_EXT;
                    {addr_d, id_d, len_d, size_d, burst_d} = {s.awaddr, s.awid, s.awlen, s.awsize, s.awburst};
                end
            AR_EXT:  if (m.arready) state_d = R_EXT;
            R_EXT:   if (m.rvalid && s.rready && m.rlast) state_d = IDLE;
            R_CLINT: if (s.rready) state_d = IDLE;
            AW_EXT:  if (m.awready) state_d = W_EXT;
            W_EXT:   if (s.wvalid && m.wready && s.wlast) state_d = B_EXT;
            W_CLINT: if (s.wvalid && s.wlast) state_d = B_CLINT;
            B_EXT:   if (m.bvalid && s.bready) state_d = IDLE;
            B_CLINT: if (s.bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shadow captures the high word in the same cycle the low word is returned, giving a coherent 64-bit pair.
    always_comb begin
        presc_d  = tick ? 16'd0 : presc_q + 16'd1;
        mtime_d  = mtime_q + 64'(tick);
        shadow_d = (state_q == R_CLINT && s.rready && off_lo) ? mtime_q[63:32] : shadow_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            presc_q  <= '0;
            mtime_q  <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            presc_q  <= presc_d;
            mtime_q  <= mtime_d;
            shadow_q <= shadow_d;
        end
    end

    assign s.arready = idle;
    assign s.awready = idle && !s.arvalid;
    assign m.arvalid = state_q == AR_EXT;
    assign m.awvalid = state_q == AW_EXT;
    assign {m.araddr, m.arid, m.arlen, m.arsize, m.arburst} = {addr_q, id_q, len_q, size_q, burst_q};
    assign {m.awaddr, m.awid, m.awlen, m.awsize, m.awburst} = {addr_q, id_q, len_q, size_q, burst_q};
    assign m.wvalid  = state_q == W_EXT && s.wvalid;
    assign {m.wdata, m.wstrb, m.wlast} = {s.wdata, s.wstrb, s.wlast};
    assign s.wready  = state_q == W_EXT ? m.wready : state_q == W_CLINT;
    assign m.bready  = state_q == B_EXT && s.bready;
    assign s.bvalid  = state_q == B_EXT ? m.bvalid : state_q == B_CLINT;
    assign s.bresp   = state_q == B_EXT ? m.bresp : 2'b10;
    assign s.bid     = state_q == B_EXT ? m.bid : id_q;
    assign m.rready  = state_q == R_EXT && s.rready;
    assign s.rvalid  = state_q == R_EXT ? m.rvalid : state_q == R_CLINT;
    assign s.rdata   = state_q == R_EXT ? m.rdata : clint_rdata;
    assign s.rresp   = state_q == R_EXT ? m.rresp : (off_lo || off_hi) ? 2'b00 : 2'b10;
    assign s.rlast   = state_q == R_EXT ? m.rlast : 1'b1;
    assign s.rid     = state_q == R_EXT ? m.rid : id_q;
endmodule

// File: tb/tb_axi_clint_xbar.sv
// tb_axi_clint_xbar: directed plus randomized transactions against a cycle-count model of mtime and the CLINT rules.
module tb_axi_clint_xbar;
    localparam int unsigned DIV = 1;
    localparam logic [31:0] BASE = 32'h0200_0000, MASK = 32'hFFFF_0000;
    logic        clock = 0, rst_n = 0;
    logic [63:0] mtime, cyc = 0;
    logic [31:0] shadow_m = 0;
    int          checks = 0, failures = 0;

    axi_clint_xbar_if s_if();
    axi_clint_xbar_if m_if();
    axi_clint_xbar #(.CLINT_BASE(BASE), .CLINT_MASK(MASK), .MTIME_DIV(DIV)) dut (
        .clock(clock), .reset(rst_n), .s(s_if), .m(m_if), .mtime(mtime));

    always #5 clock = ~clock;
    // Model time base: clock edges seen out of reset; mtime is this divided by DIV.
    always @(posedge clock) cyc <= rst_n ? cyc + 64'd1 : 64'd0;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] id, input int dly);
        logic [31:0] xd, off, ed;
        logic [1:0]  xr, er;
        logic [7:0]  ln;
        xd = $urandom;
        xr = 2'($urandom_range(0, 3));
        ln = 8'($urandom_range(0, 3));
        off = a & ~MASK;
        s_if.arvalid = 1; s_if.araddr = a; s_if.arid = id; s_if.arlen = ln; s_if.arsize = 3'd2; s_if.arburst = 2'd1;
        #1 chk("ar_ready", s_if.arready, 1);
        @(negedge clock);
        s_if.arvalid = 0;
        #1;
        if ((a & MASK) == BASE) begin
            chk("clint_rvalid", s_if.rvalid, 1);
            s_if.rready = 1;
            #1;
            ed = off == 32'hBFF8 ? 32'(cyc / DIV) : off == 32'hBFFC ? shadow_m : 32'd0;
            er = (off == 32'hBFF8 || off == 32'hBFFC) ? 2'b00 : 2'b10;
            chk("clint_rdata", s_if.rdata, ed);
            chk("clint_rresp", s_if.rresp, er);
            chk("clint_rlast", s_if.rlast, 1);
            chk("clint_rid", s_if.rid, id);
            if (off == 32'hBFF8) shadow_m = 32'((cyc / DIV) >> 32);
            @(negedge clock);
            s_if.rready = 0;
        end else begin
            chk("m_arvalid", m_if.arvalid, 1);
            chk("m_araddr", m_if.araddr, a);
            chk("m_arid", m_if.arid, id);
            chk("m_arlen", m_if.arlen, ln);
            m_if.arready = 1;
            @(negedge clock);
            m_if.arready = 0;
            #1 chk("r_wait_rvalid", s_if.rvalid, 0);
            repeat (dly) @(negedge clock);
            m_if.rvalid = 1; m_if.rdata = xd; m_if.rresp = xr; m_if.rlast = 1; m_if.rid = id;
            s_if.rready = 1;
            #1;
            chk("ext_rvalid", s_if.rvalid, 1);
            chk("ext_rdata", s_if.rdata, xd);
            chk("ext_rresp", s_if.rresp, xr);
            chk("ext_rid", s_if.rid, id);
            chk("ext_rready", m_if.rready, 1);
            @(negedge clock);
            m_if.rvalid = 0; s_if.rready = 0;
        end
        #1 chk("idle_after_read", s_if.arready, 1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d, input logic [3:0] st);
        logic [1:0] xr;
        xr = 2'($urandom_range(0, 3));
        s_if.awvalid = 1; s_if.awaddr = a; s_if.awid = id; s_if.awlen = 0; s_if.awsize = 3'd2; s_if.awburst = 2'd1;
        #1 chk("aw_ready", s_if.awready, 1);
        @(negedge clock);
        s_if.awvalid = 0; s_if.wvalid = 1; s_if.wdata = d; s_if.wstrb = st; s_if.wlast = 1;
        #1;
        if ((a & MASK) == BASE) begin
            chk("clint_wready", s_if.wready, 1);
            @(negedge clock);
            s_if.wvalid = 0;
            #1;
            chk("clint_bvalid", s_if.bvalid, 1);
            chk("clint_bresp", s_if.bresp, 2'b10);
            chk("clint_bid", s_if.bid, id);
            s_if.bready = 1;
            @(negedge clock);
            s_if.bready = 0;
        end else begin
            chk("aw_ext_wvalid", m_if.wvalid, 0);
            chk("m_awvalid", m_if.awvalid, 1);
            chk("m_awaddr", m_if.awaddr, a);
            chk("m_awid", m_if.awid, id);
            m_if.awready = 1;
            @(negedge clock);
            m_if.awready = 0; m_if.wready = 1;
            #1;
            chk("m_wvalid", m_if.wvalid, 1);
            chk("m_wdata", m_if.wdata, d);
            chk("m_wstrb", m_if.wstrb, st);
            chk("ext_wready", s_if.wready, 1);
            @(negedge clock);
            m_if.wready = 0; s_if.wvalid = 0;
            m_if.bvalid = 1; m_if.bresp = xr; m_if.bid = id; s_if.bready = 1;
            #1;
            chk("ext_bvalid", s_if.bvalid, 1);
            chk("ext_bresp", s_if.bresp, xr);
            chk("ext_bid", s_if.bid, id);
            chk("ext_bready", m_if.bready, 1);
            @(negedge clock);
            m_if.bvalid = 0; s_if.bready = 0;
        end
        #1 chk("idle_after_write", s_if.arready, 1);
    endtask

    initial begin
        logic [31:0] a, r;
        {s_if.awvalid, s_if.awaddr, s_if.awid, s_if.awlen, s_if.awsize, s_if.awburst} = '0;
        {s_if.wvalid, s_if.wdata, s_if.wstrb, s_if.wlast, s_if.bready, s_if.rready} = '0;
        {s_if.arvalid, s_if.araddr, s_if.arid, s_if.arlen, s_if.arsize, s_if.arburst} = '0;
        {m_if.awready, m_if.wready, m_if.bvalid, m_if.bresp, m_if.bid, m_if.arready} = '0;
        {m_if.rvalid, m_if.rdata, m_if.rresp, m_if.rlast, m_if.rid} = '0;
        repeat (3) @(negedge clock);
        chk("rst_mtime", mtime, 0);
        chk("rst_m_valids", {m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.bready, m_if.rready}, 0);
        chk("rst_s_valids", {s_if.rvalid, s_if.bvalid, s_if.wready}, 0);
        chk("rst_arready", s_if.arready, 1);
        rst_n = 1;
        repeat (100) @(negedge clock);
        #1 chk("mtime_100", mtime, cyc / DIV);
        rd(BASE | 32'hBFF8, 4'd1, 0);
        rd(BASE | 32'hBFFC, 4'd2, 0);
        rd(32'h8000_0000, 4'd3, 5);
        wr(32'h1000_0000, 4'd4, 32'h41, 4'b0001);
        s_if.awvalid = 1; s_if.awaddr = 32'h1000_0004;
        s_if.arvalid = 1; s_if.araddr = BASE | 32'hBFF8;
        #1 chk("both_awready", s_if.awready, 0);
        rd(BASE | 32'hBFF8, 4'd5, 0);
        chk("after_read_awready", s_if.awready, 1);
        wr(32'h1000_0004, 4'd6, 32'h42, 4'b0011);
        wr(BASE | 32'hBFF8, 4'd7, 32'h1234_5678, 4'hF);
        chk("mtime_after_wr", mtime, cyc / DIV);
        rd(BASE | 32'h0004, 4'd8, 0);
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            case ($urandom_range(0, 4))
                0: a = BASE | 32'hBFF8;
                1: a = BASE | 32'hBFFC;
                2: a = BASE | (r & 32'h0000_FFFC);
                default: a = ((r & MASK) == BASE) ? r ^ 32'h8000_0000 : r;
            endcase
            if ($urandom_range(0, 2) == 0) wr(a, 4'($urandom), $urandom, 4'($urandom));
            else rd(a, 4'($urandom), int'($urandom_range(0, 4)));
            chk("mtime_track", mtime, cyc / DIV);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        force dut.mtime_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("wrap_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_next", dut.mtime_d, 64'd0);
        release dut.mtime_q;
        @(negedge clock);
        s_if.arvalid = 1; s_if.araddr = 32'h8000_0010; s_if.arid = 4'd9;
        @(negedge clock);
        s_if.arvalid = 0; m_if.arready = 1;
        @(negedge clock);
        m_if.arready = 0; m_if.rvalid = 1; m_if.rdata = 32'hCAFE_F00D; m_if.rlast = 1; m_if.rid = 4'd9;
        #1 chk("pre_rst_rvalid", s_if.rvalid, 1);
        #1 rst_n = 0;
        #1;
        chk("rst_mid_rvalid", s_if.rvalid, 0);
        chk("rst_mid_idle", s_if.arready, 1);
        chk("rst_mid_mtime", mtime, 0);
        chk("rst_mid_rready", m_if.rready, 0);
        m_if.rvalid = 0;
        shadow_m = 0;
        @(negedge clock);
        rst_n = 1;
        repeat (10) @(negedge clock);
        #1 chk("mtime_post_rst", mtime, cyc / DIV);
        rd(BASE | 32'hBFFC, 4'd10, 0);
        rd(BASE | 32'hBFF8, 4'd11, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_clint_xbar.md
Name: axi_clint_xbar

Overview:
- AXI4 1-to-2 address router directly downstream of the core's AXI master port.
- Forwards every transaction outside the CLINT window unchanged to the external SoC master port.
- Serves transactions inside the CLINT window from an internal 64-bit mtime counter.
- Handles one outstanding transaction at a time, matching the core's blocking single-cycle execute model.

Parameters:
- CLINT_BASE, 32'h0200_0000, base address of the CLINT window.
- CLINT_MASK, 32'hFFFF_0000, the window is hit when (addr & CLINT_MASK) == CLINT_BASE.
- MTIME_DIV, 1, clock cycles per mtime increment; legal range 1..65535.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- s_aw{valid,ready,addr[31:0],id[3:0],len[7:0],size[2:0],burst[1:0]}  slave (from core)  AW channel; ready is an output, the rest are inputs.
- s_w{valid,ready,data[31:0],strb[3:0],last}  slave  W channel.
- s_b{valid,ready,resp[1:0],id[3:0]}  slave  B channel; valid/resp/id are outputs.
- s_ar{valid,ready,addr[31:0],id[3:0],len[7:0],size[2:0],burst[1:0]}  slave  AR channel.
- s_r{valid,ready,resp[1:0],data[31:0],last,id[3:0]}  slave  R channel.
- m_aw*, m_w*, m_b*, m_ar*, m_r*  master (to SoC)  the same fields as the slave side with directions mirrored.
- mtime  out  64  live counter value, for the timer-interrupt comparator.

Behaviour:
- Reset state: FSM IDLE, mtime=0, prescaler=0, shadow_hi=0. Every m_*valid, s_rvalid and s_bvalid is 0; m_bready and m_rready are 0.
- FSM states: IDLE, AR_EXT, R_EXT, R_CLINT, AW_EXT, W_EXT, B_EXT, W_CLINT, B_CLINT.
- IDLE handshake:
  - s_arready = (state==IDLE).
  - s_awready = (state==IDLE) && !s_arvalid, so reads win a simultaneous request.
  - On a handshake, latch addr/id/len/size/burst and decode the window.
  - Read: hit goes to R_CLINT, miss goes to AR_EXT. Write: hit goes to W_CLINT, miss goes to AW_EXT.
- AR_EXT: m_arvalid=1 carrying the latched fields; on m_arready go to R_EXT.
- R_EXT: R channel is passed through combinationally (s_rvalid=m_rvalid, m_rready=s_rready, data/resp/last/id forwarded). On an s_rvalid&&s_rready&&s_rlast beat go to IDLE.
- AW_EXT: m_awvalid=1 carrying the latched fields; on m_awready go to W_EXT.
- W_EXT: W channel is passed through combinationally. On the wlast handshake go to B_EXT.
- B_EXT: B channel is passed through combinationally. On the bvalid&&bready handshake go to IDLE.
- R_CLINT:
  - Drives s_rvalid=1, s_rlast=1, s_rid=latched id.
  - Offset 0xBFF8: rdata=mtime[31:0], resp OKAY, and shadow_hi<=mtime[63:32] at the R handshake.
  - Offset 0xBFFC: rdata=shadow_hi, resp OKAY.
  - Any other offset: rdata=0, resp SLVERR (2'b10).
  - Go to IDLE on s_rready. arlen is ignored; exactly one beat is returned.
- W_CLINT: s_wready=1 and beats are discarded. On the wlast handshake go to B_CLINT.
- B_CLINT: s_bvalid=1, s_bresp=SLVERR (mtime is read-only), s_bid=latched id. Go to IDLE on s_bready.
- External-side outputs when not in the owning state: m_arvalid, m_awvalid, m_wvalid, m_bready and m_rready are 0.
- Slave-side readies: s_wready is 0 outside W_EXT/W_CLINT.
- Valid stability: a valid, once raised, holds with stable payload until its handshake (AXI rule; no combinational path from ready to valid).
- mtime counting:
  - The prescaler counts 0..MTIME_DIV-1.
  - mtime increments by 1 when the prescaler wraps, and wraps from 2^64-1 to 0.
  - Counting continues during every FSM state.
- Read-low-then-high returns a coherent 64-bit snapshot. Reading high without a prior low returns the stale shadow, which is documented behaviour.
- Latency: the CLINT read response is valid 1 cycle after the AR handshake. The external path adds 1 cycle on AR/AW and 0 cycles on R/W/B.
- Reset asserted mid-transaction: immediate return to IDLE, all valids dropped, mtime cleared. The in-flight external transaction is abandoned and the SoC is reset with it.

Test Plan:
- MTIME_DIV=1, reset released, idle 100 cycles, then read 0x0200BFF8 followed by 0x0200BFFC -> low value ~100 (exact per cycle count), high=0, both resp OKAY, rlast=1, rid echoed.
- Read 0x80000000 with id=3, len=0 while the SoC returns 0xDEADBEEF after 5 cycles -> m_araddr=0x80000000, s_rdata=0xDEADBEEF, rid=3, FSM back in IDLE the cycle after the R handshake.
- Write 0x10000000 with strb=4'b0001, data=0x41 (UART) -> m_awaddr, m_wdata and m_wstrb match, and s_bresp mirrors m_bresp.
- s_arvalid and s_awvalid asserted in the same cycle -> AR accepted first, s_awready=0 that cycle, write accepted after the read completes.
- Write 0x0200BFF8 -> s_bresp=2'b10, mtime unaffected. Read 0x02000004 -> rdata=0, rresp=2'b10.
- Force mtime to 0xFFFFFFFF_FFFFFFFF, then tick -> mtime=0. Assert reset during R_EXT with rvalid pending -> s_rvalid=0 the same cycle, state IDLE.
